// File: rtl/color_change_detector_n.sv
// Debounced colour-change detector: locks the lowest-set colour after HOLD_CYCLES
// stable enabled samples, pulses NewColor per lock change, and counts changes.
module color_change_detector_n #(
    parameter int NUM_COLORS  = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int REG_OUT     = 0,
    localparam int IDX_W = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
    localparam int RUN_W = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_COLORS-1:0] Color,
    input  logic                  Enable,
    input  logic                  ClearCount,
    output logic                  NewColor,
    output logic [IDX_W-1:0]      ColorIdx,
    output logic                  ColorValid,
    output logic [CNT_WIDTH-1:0]  ChangeCount,
    output logic                  Saturated
);

    typedef enum logic [1:0] {WHITE, LOCKED, QUAL} state_t;

    state_t           state;
    logic [IDX_W-1:0] cand;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic [IDX_W-1:0] act_idx;
    logic             act_any;
    logic             qualify;

    // Lowest set bit wins; scanning downward leaves the lowest index last.
    always_comb begin
        act_any = |Color;
        act_idx = '0;
        for (int i = NUM_COLORS - 1; i >= 0; i--)
            if (Color[i]) act_idx = IDX_W'(i);
    end

    always_comb begin
        qualify = 1'b0;
        run_inc = run + RUN_W'(1);
        if (Enable && !Reset && act_any) begin
            case (state)
                WHITE:   qualify = (HOLD_CYCLES == 1);
                LOCKED:  qualify = (HOLD_CYCLES == 1) && (act_idx != ColorIdx);
                QUAL:    qualify = (act_idx == cand) && (run_inc == RUN_W'(HOLD_CYCLES));
                default: qualify = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= WHITE;
            cand        <= '0;
            run         <= '0;
            ColorIdx    <= '0;
            ColorValid  <= 1'b0;
            ChangeCount <= '0;
        end else begin
            if (Enable) begin
                if (qualify) begin
                    ColorIdx   <= act_idx;
                    ColorValid <= 1'b1;
                    state      <= LOCKED;
                    run        <= '0;
                end else begin
                    case (state)
                        WHITE: if (act_any) begin
                            state <= QUAL;
                            cand  <= act_idx;
                            run   <= RUN_W'(1);
                        end
                        LOCKED: if (!act_any) begin
                            state      <= WHITE;
                            ColorValid <= 1'b0;
                        end else if (act_idx != ColorIdx) begin
                            state <= QUAL;
                            cand  <= act_idx;
                            run   <= RUN_W'(1);
                        end
                        QUAL: if (!act_any) begin
                            state      <= WHITE;
                            ColorValid <= 1'b0;
                            run        <= '0;
                        end else if (act_idx == cand) begin
                            run <= run_inc;
                        end else if (ColorValid && act_idx == ColorIdx) begin
                            state <= LOCKED;
                            run   <= '0;
                        end else begin
                            cand <= act_idx;
                            run  <= RUN_W'(1);
                        end
                        default: state <= WHITE;
                    endcase
                end
            end
            // Clear wins over the old value but a coincident qualification still counts.
            if (ClearCount)
                ChangeCount <= qualify ? CNT_WIDTH'(1) : '0;
            else if (qualify && !(&ChangeCount))
                ChangeCount <= ChangeCount + CNT_WIDTH'(1);
        end
    end

    assign Saturated = &ChangeCount;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic nc_q;
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) nc_q <= 1'b0;
                else       nc_q <= qualify;
            end
            // A pending pulse is dropped, not deferred, if Enable falls.
            assign NewColor = nc_q & Enable;
        end else begin : g_mealy
            assign NewColor = qualify;
        end
    endgenerate

endmodule

// File: tb/tb_color_change_detector_n.sv
// Randomized bench for color_change_detector_n: three parameter sets driven from
// shared inputs and compared every cycle against a lock/candidate reference model.
module tb_color_change_detector_n;

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [4:0] color;

    always #5 clk = ~clk;

    // A: NUM=3 HOLD=2 CNT=2 Mealy; B: NUM=5 HOLD=1 CNT=2 registered; C: NUM=4 HOLD=3 CNT=8 registered
    int nc_p[3]   = '{3, 5, 4};
    int hold_p[3] = '{2, 1, 3};
    int cmax_p[3] = '{3, 3, 255};
    int ro_p[3]   = '{0, 1, 1};

    logic       a_nc, a_val, a_sat;
    logic [1:0] a_idx, a_cnt;
    logic       b_nc, b_val, b_sat;
    logic [2:0] b_idx;
    logic [1:0] b_cnt;
    logic       c_nc, c_val, c_sat;
    logic [1:0] c_idx;
    logic [7:0] c_cnt;

    color_change_detector_n #(.NUM_COLORS(3), .HOLD_CYCLES(2), .CNT_WIDTH(2), .REG_OUT(0)) dut_a (
        .Clock(clk), .Reset(rst), .Color(color[2:0]), .Enable(en), .ClearCount(clr),
        .NewColor(a_nc), .ColorIdx(a_idx), .ColorValid(a_val), .ChangeCount(a_cnt), .Saturated(a_sat));
    color_change_detector_n #(.NUM_COLORS(5), .HOLD_CYCLES(1), .CNT_WIDTH(2), .REG_OUT(1)) dut_b (
        .Clock(clk), .Reset(rst), .Color(color[4:0]), .Enable(en), .ClearCount(clr),
        .NewColor(b_nc), .ColorIdx(b_idx), .ColorValid(b_val), .ChangeCount(b_cnt), .Saturated(b_sat));
    color_change_detector_n #(.NUM_COLORS(4), .HOLD_CYCLES(3), .CNT_WIDTH(8), .REG_OUT(1)) dut_c (
        .Clock(clk), .Reset(rst), .Color(color[3:0]), .Enable(en), .ClearCount(clr),
        .NewColor(c_nc), .ColorIdx(c_idx), .ColorValid(c_val), .ChangeCount(c_cnt), .Saturated(c_sat));

    int total = 0;
    int bad   = 0;

    // Reference model: current lock, an optional pending candidate with its run length.
    int m_idx[3], m_cand[3], m_run[3], m_cnt[3];
    bit m_val[3], m_cv[3], m_pend[3];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0; m_cand[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
            m_val[k] = 0; m_cv[k] = 0; m_pend[k] = 0;
        end
    endtask

    task automatic check_and_step();
        int o_nc[3], o_idx[3], o_val[3], o_cnt[3], o_sat[3];
        int act, r, e_nc;
        bit q;
        o_nc  = '{int'(a_nc), int'(b_nc), int'(c_nc)};
        o_idx = '{int'(a_idx), int'(b_idx), int'(c_idx)};
        o_val = '{int'(a_val), int'(b_val), int'(c_val)};
        o_cnt = '{int'(a_cnt), int'(b_cnt), int'(c_cnt)};
        o_sat = '{int'(a_sat), int'(b_sat), int'(c_sat)};
        for (int k = 0; k < 3; k++) begin
            act = -1;
            for (int i = 0; i < nc_p[k]; i++)
                if (color[i] && act < 0) act = i;
            q = 0;
            r = 1;
            if (!rst && en && act >= 0 && !(m_val[k] && act == m_idx[k])) begin
                r = (m_cv[k] && act == m_cand[k]) ? m_run[k] + 1 : 1;
                q = (r >= hold_p[k]);
            end
            if (rst) e_nc = 0;
            else     e_nc = ro_p[k] != 0 ? int'(m_pend[k] && en) : int'(q);
            chk($sformatf("%0d.new_color", k), o_nc[k], e_nc);
            chk($sformatf("%0d.color_idx", k), o_idx[k], rst ? 0 : m_idx[k]);
            chk($sformatf("%0d.color_valid", k), o_val[k], rst ? 0 : int'(m_val[k]));
            chk($sformatf("%0d.change_count", k), o_cnt[k], rst ? 0 : m_cnt[k]);
            chk($sformatf("%0d.saturated", k), o_sat[k], rst ? 0 : int'(m_cnt[k] == cmax_p[k]));
            if (!rst) begin
                if (clr) m_cnt[k] = q ? 1 : 0;
                else if (q && m_cnt[k] < cmax_p[k]) m_cnt[k]++;
                m_pend[k] = q;
                if (en) begin
                    if (act < 0) begin
                        m_val[k] = 0; m_cv[k] = 0;
                    end else if (m_val[k] && act == m_idx[k]) begin
                        m_cv[k] = 0;
                    end else if (q) begin
                        m_idx[k] = act; m_val[k] = 1; m_cv[k] = 0;
                    end else begin
                        m_cand[k] = act; m_run[k] = r; m_cv[k] = 1;
                    end
                end
            end
        end
        if (rst) model_reset();
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic cyc(input logic [4:0] c, input logic e, input logic cl, input logic r);
        color = c; en = e; clr = cl; rst = r;
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [4:0] c, input int n, input logic e);
        for (int i = 0; i < n; i++) cyc(c, e, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] c;
        model_reset();
        color = '0; en = 1'b1; clr = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(5'b00000, 1, 0, 1);
        // reset in the middle of a qualification
        cyc(5'b00010, 1, 0, 0);
        cyc(5'b00010, 1, 0, 1);
        hold(5'b00000, 10, 1);
        // glitch reject, then a real lock on colour 0
        hold(5'b00001, 1, 1);
        hold(5'b00000, 2, 1);
        hold(5'b00001, 3, 1);
        // priority and return to the locked colour
        hold(5'b00110, 1, 1);
        hold(5'b00001, 2, 1);
        hold(5'b00110, 3, 1);
        // enable freeze keeps the run alive
        hold(5'b00100, 1, 1);
        hold(5'b00100, 5, 0);
        hold(5'b00100, 2, 1);
        // saturating counter, then clear coinciding with a qualification
        for (int n = 0; n < 4; n++) hold((n % 2) ? 5'b00100 : 5'b00001, 3, 1);
        cyc(5'b00010, 1, 0, 0);
        cyc(5'b00010, 1, 1, 0);
        hold(5'b00010, 2, 1);
        // back-to-back single-cycle qualifications
        cyc(5'b00000, 1, 0, 1);
        hold(5'b00001, 1, 1);
        hold(5'b00010, 1, 1);
        hold(5'b00100, 3, 1);
        // random traffic with sticky colours so runs actually qualify
        c = 5'b00001;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 35) c = 5'($urandom_range(0, 31));
            cyc(c, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4,
                $urandom_range(0, 299) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
